// File: rtl/adc_dac_router.sv
// adc_dac_router: ADC/DAC sample router and conditioner between the board converters and the DSP chain.
//
// Ports:
//   sys_clk, rst_n              clock, asynchronous active-low reset
//   adc_ch0/1, adc_sel          raw offset-binary ADC samples and the channel feeding dsp_in
//   dsp_in                      registered, left-justified signed ADC sample for the decimator
//   down_data/valid             decimator output and clock enable, held in hold_down
//   up_data/valid               interpolator output and clock enable, held in hold_up
//   dac0/1_mode                 per-channel source: 0 adc, 1 down, 2 up, 3 const, 4 ramp, else zero
//   dac0/1_shift                per-channel power-of-two gain 0..3 with saturation
//   dac_const, ramp_step        shared constant test value and sawtooth increment
//   dac0/1_data                 offset-binary DAC words (two register stages after the source)
//   sat_flag, sat_clr           sticky per-channel clip flags and their clear
//   snap_req/ack, snap_*        req/ack snapshot of hold_down, hold_up and dsp_in
module adc_dac_router #(
    parameter int ADC_W = 12,
    parameter int DSP_W = 16,
    parameter int DAC_W = 14
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic [ADC_W-1:0] adc_ch0,
    input  logic [ADC_W-1:0] adc_ch1,
    input  logic             adc_sel,
    output logic [DSP_W-1:0] dsp_in,
    input  logic [DSP_W-1:0] down_data,
    input  logic             down_valid,
    input  logic [DSP_W-1:0] up_data,
    input  logic             up_valid,
    input  logic [2:0]       dac0_mode,
    input  logic [2:0]       dac1_mode,
    input  logic [1:0]       dac0_shift,
    input  logic [1:0]       dac1_shift,
    input  logic [DSP_W-1:0] dac_const,
    input  logic [DSP_W-1:0] ramp_step,
    output logic [DAC_W-1:0] dac0_data,
    output logic [DAC_W-1:0] dac1_data,
    output logic [1:0]       sat_flag,
    input  logic             sat_clr,
    input  logic             snap_req,
    output logic             snap_ack,
    output logic [DSP_W-1:0] snap_down,
    output logic [DSP_W-1:0] snap_up,
    output logic [DSP_W-1:0] snap_adc
);
    localparam logic [DAC_W-1:0] DAC_MID = {1'b1, {(DAC_W-1){1'b0}}};

    logic [1:0][DSP_W-1:0] cvt_q, cvt_d, src, s1_q, s1_d;
    logic [1:0][DSP_W+2:0] ext;
    logic [1:0][DAC_W-1:0] dac_q, dac_d;
    logic [1:0][2:0]       mode;
    logic [1:0][1:0]       shift;
    logic [1:0]            clip, sat_q, sat_d;
    logic [DSP_W-1:0]      hold_down_q, hold_up_q, ramp_q;
    logic [DSP_W-1:0]      snap_down_q, snap_up_q, snap_adc_q;
    logic                  snap_ack_q, snap_cap;
    logic                  unused_s1;

    assign mode  = {dac1_mode, dac0_mode};
    assign shift = {dac1_shift, dac0_shift};

    always_comb begin
        // Flipping the MSB turns offset binary into two's complement; left-justify into DSP_W.
        cvt_d[0] = DSP_W'({~adc_ch0[ADC_W-1], adc_ch0[ADC_W-2:0]}) << (DSP_W-ADC_W);
        cvt_d[1] = DSP_W'({~adc_ch1[ADC_W-1], adc_ch1[ADC_W-2:0]}) << (DSP_W-ADC_W);
        for (int i = 0; i < 2; i++) begin
            src[i] = (mode[i] == 3'd0) ? cvt_q[i] :
                     (mode[i] == 3'd1) ? hold_down_q :
                     (mode[i] == 3'd2) ? hold_up_q :
                     (mode[i] == 3'd3) ? dac_const :
                     (mode[i] == 3'd4) ? ramp_q : '0;
            // Sign-extend by 3 so the largest shift cannot lose magnitude before the range test.
            ext[i]  = {{3{src[i][DSP_W-1]}}, src[i]} << shift[i];
            // In range only when the guard bits and the DSP sign bit all agree.
            clip[i] = (ext[i][DSP_W+2:DSP_W-1] != '0) && (ext[i][DSP_W+2:DSP_W-1] != '1);
            s1_d[i] = clip[i] ? {ext[i][DSP_W+2], {(DSP_W-1){~ext[i][DSP_W+2]}}} : ext[i][DSP_W-1:0];
            dac_d[i] = {~s1_q[i][DSP_W-1], s1_q[i][DSP_W-2:DSP_W-DAC_W]};
        end
        // A clip in the clearing cycle wins so no overflow is ever lost.
        sat_d = clip | (sat_q & ~{2{sat_clr}});
    end

    assign snap_cap  = snap_req & ~snap_ack_q;
    assign unused_s1 = ^s1_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cvt_q       <= '0;
            hold_down_q <= '0;
            hold_up_q   <= '0;
            ramp_q      <= '0;
            s1_q        <= '0;
            dac_q       <= {DAC_MID, DAC_MID};
            sat_q       <= '0;
            snap_ack_q  <= 1'b0;
            snap_down_q <= '0;
            snap_up_q   <= '0;
            snap_adc_q  <= '0;
        end else begin
            cvt_q      <= cvt_d;
            ramp_q     <= ramp_q + ramp_step;
            s1_q       <= s1_d;
            dac_q      <= dac_d;
            sat_q      <= sat_d;
            snap_ack_q <= snap_req;
            if (down_valid) hold_down_q <= down_data;
            if (up_valid) hold_up_q <= up_data;
            // Captures see the hold values from before any same-cycle valid update.
            if (snap_cap) begin
                snap_down_q <= hold_down_q;
                snap_up_q   <= hold_up_q;
                snap_adc_q  <= dsp_in;
            end
        end
    end

    assign dsp_in    = adc_sel ? cvt_q[1] : cvt_q[0];
    assign dac0_data = dac_q[0];
    assign dac1_data = dac_q[1];
    assign sat_flag  = sat_q;
    assign snap_ack  = snap_ack_q;
    assign snap_down = snap_down_q;
    assign snap_up   = snap_up_q;
    assign snap_adc  = snap_adc_q;
endmodule

// File: tb/tb_adc_dac_router.sv
// tb_adc_dac_router: directed and randomized checks of adc_dac_router against an arithmetic reference model.
module tb_adc_dac_router;
    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] adc_ch0 = '0, adc_ch1 = '0;
    logic        adc_sel = 1'b0;
    logic [15:0] dsp_in;
    logic [15:0] down_data = '0, up_data = '0, dac_const = '0, ramp_step = '0;
    logic        down_valid = 1'b0, up_valid = 1'b0;
    logic [2:0]  dac0_mode = '0, dac1_mode = '0;
    logic [1:0]  dac0_shift = '0, dac1_shift = '0;
    logic [13:0] dac0_data, dac1_data;
    logic [1:0]  sat_flag;
    logic        sat_clr = 1'b0, snap_req = 1'b0, snap_ack;
    logic [15:0] snap_down, snap_up, snap_adc;

    int errors = 0, checks = 0;

    int          mcvt[2], ms1[2], mdac[2];
    int          mhd, mhu, msd, msu, msa;
    logic [15:0] mramp;
    logic [1:0]  msat;
    logic        mack;

    always #5 sys_clk = ~sys_clk;

    adc_dac_router dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .adc_ch0(adc_ch0), .adc_ch1(adc_ch1), .adc_sel(adc_sel), .dsp_in(dsp_in),
        .down_data(down_data), .down_valid(down_valid), .up_data(up_data), .up_valid(up_valid),
        .dac0_mode(dac0_mode), .dac1_mode(dac1_mode), .dac0_shift(dac0_shift), .dac1_shift(dac1_shift),
        .dac_const(dac_const), .ramp_step(ramp_step),
        .dac0_data(dac0_data), .dac1_data(dac1_data),
        .sat_flag(sat_flag), .sat_clr(sat_clr),
        .snap_req(snap_req), .snap_ack(snap_ack),
        .snap_down(snap_down), .snap_up(snap_up), .snap_adc(snap_adc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [31:0] w16(input int v);
        return 32'(v) & 32'h0000_FFFF;
    endfunction

    function automatic int msrc(input int c);
        logic [2:0] m;
        m = (c != 0) ? dac1_mode : dac0_mode;
        case (m)
            3'd0: return mcvt[c];
            3'd1: return mhd;
            3'd2: return mhu;
            3'd3: return s16(dac_const);
            3'd4: return s16(mramp);
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        mcvt = '{0, 0};
        ms1  = '{0, 0};
        mdac = '{8192, 8192};
        mhd = 0; mhu = 0; msd = 0; msu = 0; msa = 0;
        mramp = '0; msat = '0; mack = 1'b0;
    endtask

    task automatic compare_all();
        check("dsp_in", dsp_in, w16(adc_sel ? mcvt[1] : mcvt[0]));
        check("dac0", dac0_data, 32'(mdac[0]));
        check("dac1", dac1_data, 32'(mdac[1]));
        check("sat_flag", sat_flag, msat);
        check("snap_ack", snap_ack, mack);
        check("snap_down", snap_down, w16(msd));
        check("snap_up", snap_up, w16(msu));
        check("snap_adc", snap_adc, w16(msa));
    endtask

    // Reference model: values as plain signed integers, gain as multiplication, clamp by comparison.
    task automatic tick();
        int nd[2], ns1[2], v, dsp_old;
        logic [1:0] clip;
        @(posedge sys_clk);
        dsp_old = adc_sel ? mcvt[1] : mcvt[0];
        for (int c = 0; c < 2; c++) begin
            nd[c]   = (ms1[c] + 32768) / 4;
            v       = msrc(c) * (1 << ((c != 0) ? dac1_shift : dac0_shift));
            clip[c] = (v > 32767) || (v < -32768);
            ns1[c]  = (v > 32767) ? 32767 : (v < -32768) ? -32768 : v;
        end
        msat = clip | (sat_clr ? 2'b00 : msat);
        if (snap_req && !mack) begin
            msd = mhd; msu = mhu; msa = dsp_old;
        end
        mack = snap_req;
        mdac = nd;
        ms1  = ns1;
        mcvt[0] = (int'(adc_ch0) - 2048) * 16;
        mcvt[1] = (int'(adc_ch1) - 2048) * 16;
        if (down_valid) mhd = s16(down_data);
        if (up_valid) mhu = s16(up_data);
        mramp = mramp + ramp_step;
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_dac0", dac0_data, 32'h2000);
        check("rst_dac1", dac1_data, 32'h2000);
        check("rst_ack", snap_ack, 32'h0);
        check("rst_sat", sat_flag, 32'h0);
        check("rst_dsp_in", dsp_in, 32'h0);
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int wraps;
        logic [13:0] prev, d;
        #1;
        do_reset();

        adc_ch0 = 12'hFFF; adc_sel = 1'b0; dac0_mode = 3'd0; dac0_shift = 2'd0;
        tick();
        check("loop_dsp_in", dsp_in, 32'h7FF0);
        tick(); tick();
        check("loop_dac0_max", dac0_data, 32'h3FFC);
        adc_ch0 = 12'h000;
        repeat (3) tick();
        check("loop_dac0_min", dac0_data, 32'h0000);

        dac0_mode = 3'd1; dac0_shift = 2'd1; down_data = 16'h5000; down_valid = 1'b1;
        tick();
        down_valid = 1'b0;
        tick(); tick();
        check("sat_hi_dac0", dac0_data, 32'h3FFF);
        check("sat_hi_flag", sat_flag[0], 32'h1);
        tick(); tick();
        check("sat_sticky", sat_flag[0], 32'h1);
        dac0_shift = 2'd0;
        tick();
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("sat_cleared", sat_flag[0], 32'h0);
        down_data = 16'hB000; down_valid = 1'b1; dac0_shift = 2'd1;
        tick();
        down_valid = 1'b0;
        tick(); tick();
        check("sat_lo_dac0", dac0_data, 32'h0000);
        check("sat_lo_flag", sat_flag[0], 32'h1);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("sat_clr_vs_clip", sat_flag[0], 32'h1);

        dac1_mode = 3'd2; dac1_shift = 2'd0; up_data = 16'h1234; up_valid = 1'b1;
        tick();
        up_data = 16'h7777; up_valid = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_dac1", dac1_data, 32'h248D);
        end

        do_reset();
        down_data = 16'h0100; down_valid = 1'b1;
        tick();
        down_data = 16'h0200; snap_req = 1'b1;
        tick();
        check("snap_old_hold", snap_down, 32'h0100);
        check("snap_ack_rise", snap_ack, 32'h1);
        down_data = 16'h0300;
        tick();
        check("snap_frozen", snap_down, 32'h0100);
        snap_req = 1'b0; down_valid = 1'b0;
        tick();
        check("snap_ack_fall", snap_ack, 32'h0);
        snap_req = 1'b1;
        tick();
        check("snap_ack_again", snap_ack, 32'h1);
        do_reset();
        snap_req = 1'b0;

        dac1_mode = 3'd4; dac1_shift = 2'd0; ramp_step = 16'h0100;
        do_reset();
        wraps = 0;
        prev = dac1_data;
        for (int k = 0; k < 140; k++) begin
            tick();
            d = dac1_data - prev;
            if (prev == 14'h3FC0) begin
                check("ramp_wrap", dac1_data, 32'h0000);
                wraps++;
            end else if (k >= 2) begin
                check("ramp_inc", d, 32'h40);
            end
            prev = dac1_data;
        end
        check("ramp_wrap_seen", wraps, 32'd1);

        for (int k = 0; k < 400; k++) begin
            adc_ch0    = 12'($urandom);
            adc_ch1    = 12'($urandom);
            adc_sel    = 1'($urandom);
            down_data  = 16'($urandom);
            up_data    = 16'($urandom);
            down_valid = 1'($urandom);
            up_valid   = 1'($urandom);
            dac0_mode  = 3'($urandom_range(0, 7));
            dac1_mode  = 3'($urandom_range(0, 7));
            dac0_shift = 2'($urandom);
            dac1_shift = 2'($urandom);
            dac_const  = 16'($urandom);
            ramp_step  = 16'($urandom);
            sat_clr    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) snap_req = ~snap_req;
            if (k == 200) do_reset();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adc_dac_router.md
# adc_dac_router

Parametrised sample router and conditioner between the board ADC/DAC pins and the DSP filter chain, with two ADC channels and two DAC channels. It converts raw offset-binary ADC samples to left-justified signed DSP words and holds the decimator/interpolator outputs on their clock enables. Each DAC channel has a run-time source mode, power-of-two gain with saturation, test-pattern generation, sticky overflow flags, and a req/ack snapshot port for CSR readback.

## Interface
- `ADC_W`, default 12: ADC sample width, offset binary; `ADC_W <= DSP_W`.
- `DSP_W`, default 16: signed DSP word width.
- `DAC_W`, default 14: DAC word width, offset binary; `DAC_W <= DSP_W`.

Single clock domain. Reset is asynchronous, active-low.
- `sys_clk`  in  1  clock.
- `rst_n`  in  1  async active-low reset.
- `adc_ch0`, `adc_ch1`  in  ADC_W  raw ADC samples, offset binary.
- `adc_sel`  in  1  selects the ADC channel that feeds `dsp_in` (0 = ch0).
- `dsp_in`  out  DSP_W  converted ADC sample for the decimator.
- `down_data`  in  DSP_W, `down_valid`  in  1  decimator output and its ce.
- `up_data`  in  DSP_W, `up_valid`  in  1  interpolator output and its ce.
- `dac0_mode`, `dac1_mode`  in  3  per-channel source select.
- `dac0_shift`, `dac1_shift`  in  2  per-channel left shift, 0..3.
- `dac_const`  in  DSP_W  constant test value, shared by both channels.
- `ramp_step`  in  DSP_W  sawtooth increment per cycle.
- `dac0_data`, `dac1_data`  out  DAC_W  DAC words, offset binary.
- `sat_flag`  out  2  sticky saturation flags, bit n = DAC channel n.
- `sat_clr`  in  1  clears `sat_flag`.
- `snap_req`  in  1, `snap_ack`  out  1  snapshot handshake.
- `snap_down`, `snap_up`, `snap_adc`  out  DSP_W  snapshot data.

## Operation
- **ADC conversion.** Register `cvtN <= {~adc_chN[MSB], adc_chN[ADC_W-2:0], (DSP_W-ADC_W) zeros}` every cycle. `dsp_in = adc_sel ? cvt1 : cvt0`.
- **Hold registers.** `hold_down <= down_data` when `down_valid`. `hold_up <= up_data` when `up_valid`. Otherwise both keep their value.
- **Ramp.** `ramp <= ramp + ramp_step` every cycle, wrapping modulo 2^DSP_W.
- **Mode decode per channel n:**
  - 0: `cvtn` (ADC loopback on the same channel index).
  - 1: `hold_down`.
  - 2: `hold_up`.
  - 3: `dac_const`.
  - 4: `ramp`.
  - 5, 6, 7: zero (midscale).
- **Stage 1.** Compute `src <<< shift` at DSP_W+3 bits, then saturate to DSP_W: above max gives 2^(DSP_W-1)-1, below min gives -2^(DSP_W-1). Any clipping sets `sat_flag[n]`.
- **Stage 2.** `dacn_data <= {~s1[DSP_W-1], s1[DSP_W-2:DSP_W-DAC_W]}`. This truncates to the top DAC_W bits and converts to offset binary.
- **sat_flag.** Set and `sat_clr` in the same cycle leaves the flag set.
- **Snapshot handshake:**
  - When `snap_req=1` and `snap_ack=0`, capture `hold_down`, `hold_up` and `dsp_in` into the snap registers, then raise `snap_ack` the next cycle.
  - `snap_ack` stays high until `snap_req` drops, then falls the next cycle.
  - The snap registers do not change while `snap_ack=1`.
  - A capture in the same cycle as `down_valid` or `up_valid` takes the pre-update (old) hold value.
- **Mode or shift change.** Takes effect on the next stage-1 register. There is no glitch suppression beyond the registered pipeline.

## Timing
- **Reset values:**
  - `cvt*`, holds, ramp, stage-1 registers, snap registers, `sat_flag`: 0.
  - `snap_ack`: 0.
  - `dac*_data`: 2^(DAC_W-1) (midscale, 0x2000 at the defaults).
- **Latency:**
  - ADC pin to `dsp_in`: 1 cycle.
  - Pin to DAC in mode 0: 3 cycles.
  - Source register to `dacN_data`: 2 cycles. A `valid` edge therefore reaches the DAC 3 cycles after the valid cycle.
- **Handshake.** `snap_req` to `snap_ack` rise: 1 cycle. `snap_req` fall to `snap_ack` fall: 1 cycle.
- **Reset mid-operation.** Asserting `rst_n` low forces every output to its reset value immediately (asynchronously). An in-flight snapshot is abandoned and `snap_ack` reads 0.
- **Throughput.** Every path accepts one sample per cycle, with no stalls.

## Test plan
- **Reset.** Hold `rst_n` low.
  - Required: `dac0_data=dac1_data=0x2000`, `snap_ack=0`, `sat_flag=0`, `dsp_in=0`.
- **Loopback.** `adc_ch0=0xFFF`, `adc_sel=0`, `dac0_mode=0`, `shift=0`.
  - Required: `dsp_in=0x7FF0` after 1 cycle; `dac0_data=0x3FFC` after 3 cycles.
  - Then `adc_ch0=0x000`: `dac0_data=0x0000`.
- **Saturation.** `down_data=0x5000` with one `down_valid` pulse, `dac0_mode=1`, `dac0_shift=1`.
  - Required: `dac0_data=0x3FFF` and `sat_flag[0]=1` until `sat_clr`.
  - Then `down_data=0xB000`: `dac0_data=0x0000`.
  - `sat_clr` asserted in the same cycle as a new clip: the flag stays 1.
- **Hold.** `up_valid` pulse with `up_data=0x1234`, then `up_data=0x7777` with `up_valid=0`, `dac1_mode=2`.
  - Required: `dac1_data` stays at 0x248D.
- **Snapshot.** `hold_down=0x0100`. Raise `snap_req` in the same cycle as `down_valid` with `down_data=0x0200`.
  - Required: `snap_down=0x0100` and `snap_ack=1` on the next cycle.
  - `snap_ack` falls 1 cycle after `snap_req` drops.
  - Reset asserted while `snap_ack=1`: `snap_ack=0` immediately.
- **Ramp.** `ramp_step=0x0100`, `dac1_mode=4`.
  - Required: `dac1_data` increases by 0x40 per cycle.
  - When the ramp wraps from 0x7F00 to 0x8000, `dac1_data` goes from 0x3FC0 to 0x0000.
